// File: rtl/npc_fetch_pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : npc_fetch_pc_pkg
//  Purpose  : Shared constants for the F-stage next-PC logic. The D-stage
//             controller imports the NPCOp encodings from here too.
//  Contents : NPC_* opcode encodings, reset PC, instruction-memory range,
//             and a helper that tests whether a PC is a legal fetch address.
//  Revision : 1.0  initial release
// ============================================================================
package npc_fetch_pc_pkg;

    // Next-PC operation selected by the D-stage controller
    localparam logic [2:0] NPC_SEQ = 3'b000;  // sequential, PC+4
    localparam logic [2:0] NPC_BR  = 3'b001;  // conditional branch
    localparam logic [2:0] NPC_J   = 3'b010;  // j / jal
    localparam logic [2:0] NPC_JR  = 3'b011;  // jr / jalr
    localparam logic [2:0] NPC_BRL = 3'b100;  // branch-likely

    // Default fetch PC after reset and instruction-memory geometry
    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam int unsigned IM_WORDS = 4096;

    // A fetch address is legal when word aligned and inside [base, last]
    function automatic logic pc_is_legal(
        input logic [31:0] pc,
        input logic [31:0] base,
        input logic [31:0] last
    );
        return (pc[1:0] == 2'b00) && (pc >= base) && (pc <= last);
    endfunction

endpackage : npc_fetch_pc_pkg
`default_nettype wire

// File: rtl/npc_fetch_pc_target.sv
`default_nettype none
// ============================================================================
//  Module   : npc_target
//  Purpose  : Purely combinational target adders for the next-PC selector.
//  Ports    : D_PC_i      PC of the instruction in D
//             D_imm16_i   branch offset in words (sign-extended)
//             D_imm26_i   jump index
//             D_rs_i      forwarded rs for jr/jalr
//             br_o        D_PC+4+sext(imm16)*4 (wraps at 32 bits)
//             j_o         {D_PC[31:28], imm26, 2'b00}
//             jr_o        D_rs
//             pc8_o       D_PC+8 (link value / not-taken likely target)
//  Revision : 1.0  initial release
// ============================================================================
module npc_target (
    input  logic [31:0] D_PC_i,
    input  logic [15:0] D_imm16_i,
    input  logic [25:0] D_imm26_i,
    input  logic [31:0] D_rs_i,
    output logic [31:0] br_o,
    output logic [31:0] j_o,
    output logic [31:0] jr_o,
    output logic [31:0] pc8_o
);

    logic [31:0] w_br_offset;

    // Word offset turned into a byte offset with sign extension
    assign w_br_offset = {{14{D_imm16_i[15]}}, D_imm16_i, 2'b00};

    assign br_o  = D_PC_i + 32'd4 + w_br_offset;
    assign j_o   = {D_PC_i[31:28], D_imm26_i, 2'b00};
    assign jr_o  = D_rs_i;
    assign pc8_o = D_PC_i + 32'd8;

endmodule : npc_target
`default_nettype wire

// File: rtl/npc_fetch_pc.sv
`default_nettype none
// ============================================================================
//  Module   : npc_fetch_pc
//  Purpose  : F-stage program counter and next-PC selector. Chooses between
//             sequential, branch, jump and register targets, handles the
//             delay slot and squashes it for not-taken branch-likely forms.
//  Ports    : clk          system clock, rising edge
//             reset        asynchronous, active-high
//             stall        freeze: PC holds, no redirect or squash
//             D_NPCOp      next-PC operation (undefined codes = sequential)
//             D_b_result   branch decision from the D-stage comparator
//             D_PC         PC of the instruction in D
//             D_imm16      branch offset in words
//             D_imm26      jump index
//             D_rs         forwarded rs for jr/jalr
//             F_PC         current fetch address
//             F_squash     clear the F->D register this edge
//             F_addr_err   sticky illegal-PC flag, cleared only by reset
//             D_PC8        D_PC+8, link value for jal/jalr
//  Revision : 1.0  initial release
// ============================================================================
module npc_fetch_pc #(
    parameter logic [31:0] PC_RESET = npc_fetch_pc_pkg::PC_RESET,
    parameter logic [31:0] IM_BASE  = npc_fetch_pc_pkg::IM_BASE,
    parameter int unsigned IM_WORDS = npc_fetch_pc_pkg::IM_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  D_NPCOp,
    input  logic        D_b_result,
    input  logic [31:0] D_PC,
    input  logic [15:0] D_imm16,
    input  logic [25:0] D_imm26,
    input  logic [31:0] D_rs,
    output logic [31:0] F_PC,
    output logic        F_squash,
    output logic        F_addr_err,
    output logic [31:0] D_PC8
);

    import npc_fetch_pc_pkg::*;

    // Address of the last legal instruction word
    localparam logic [31:0] IM_LAST = IM_BASE + 32'(4 * IM_WORDS) - 32'd4;

    logic [31:0] pc_q, pc_d;
    logic        err_q, err_d;

    logic [31:0] br_tgt, j_tgt, jr_tgt, pc8;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;

    npc_target u_target (
        .D_PC_i    (D_PC),
        .D_imm16_i (D_imm16),
        .D_imm26_i (D_imm26),
        .D_rs_i    (D_rs),
        .br_o      (br_tgt),
        .j_o       (j_tgt),
        .jr_o      (jr_tgt),
        .pc8_o     (pc8)
    );

    assign pc_plus4 = pc_q + 32'd4;

    // Next-PC select. A not-taken likely branch skips the delay slot, so the
    // fall-through is D_PC+8 rather than F_PC+4.
    always_comb begin
        next_pc = pc_plus4;
        case (D_NPCOp)
            NPC_BR:  next_pc = D_b_result ? br_tgt : pc_plus4;
            NPC_J:   next_pc = j_tgt;
            NPC_JR:  next_pc = jr_tgt;
            NPC_BRL: next_pc = D_b_result ? br_tgt : pc8;
            default: next_pc = pc_plus4;
        endcase
    end

    // Stall freezes the PC; the redirect is re-evaluated when it lifts.
    // The error flag only latches a PC that is actually loaded.
    always_comb begin
        pc_d  = pc_q;
        err_d = err_q;
        if (!stall) begin
            pc_d  = next_pc;
            err_d = err_q | ~pc_is_legal(next_pc, IM_BASE, IM_LAST);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= PC_RESET;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

    assign F_PC       = pc_q;
    assign F_addr_err = err_q;
    assign D_PC8      = pc8;
    assign F_squash   = !reset && !stall && (D_NPCOp == NPC_BRL) && !D_b_result;

endmodule : npc_fetch_pc
`default_nettype wire

// File: tb/tb_npc_fetch_pc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_npc_fetch_pc
//  Purpose  : Self-checking bench for npc_fetch_pc. A driver applies one
//             D-stage request per cycle and pushes the expected response;
//             a monitor pops and compares against the DUT outputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_npc_fetch_pc;

    localparam logic [31:0] C_PC_RESET = 32'h0000_3000;
    localparam logic [31:0] C_IM_LO    = 32'h0000_3000;
    localparam logic [31:0] C_IM_HI    = 32'h0000_6FFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [2:0]  D_NPCOp;
    logic        D_b_result;
    logic [31:0] D_PC;
    logic [15:0] D_imm16;
    logic [25:0] D_imm26;
    logic [31:0] D_rs;
    logic [31:0] F_PC;
    logic        F_squash;
    logic        F_addr_err;
    logic [31:0] D_PC8;

    always #5 clk = ~clk;

    npc_fetch_pc dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .D_NPCOp    (D_NPCOp),
        .D_b_result (D_b_result),
        .D_PC       (D_PC),
        .D_imm16    (D_imm16),
        .D_imm26    (D_imm26),
        .D_rs       (D_rs),
        .F_PC       (F_PC),
        .F_squash   (F_squash),
        .F_addr_err (F_addr_err),
        .D_PC8      (D_PC8)
    );

    typedef struct {
        logic        sq;
        logic [31:0] pc8;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_pc;
    logic        model_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: where the program goes next for one request
    task automatic drive(input logic [2:0] op, input logic b, input logic [31:0] dpc,
                         input logic [15:0] i16, input logic [25:0] i26,
                         input logic [31:0] rs, input logic st);
        exp_t        e;
        logic [31:0] br, jt, nxt;
        @(negedge clk);
        D_NPCOp = op; D_b_result = b; D_PC = dpc; D_imm16 = i16;
        D_imm26 = i26; D_rs = rs; stall = st;
        #1;
        br = dpc + 32'd4 + 32'($signed(i16)) * 32'd4;
        jt = (dpc & 32'hF000_0000) | (32'(i26) << 2);
        if (op == 3'd1)      nxt = b ? br : model_pc + 32'd4;
        else if (op == 3'd2) nxt = jt;
        else if (op == 3'd3) nxt = rs;
        else if (op == 3'd4) nxt = b ? br : dpc + 32'd8;
        else                 nxt = model_pc + 32'd4;
        e.sq  = !st && (op == 3'd4) && !b;
        e.pc8 = dpc + 32'd8;
        if (!st) begin
            model_pc = nxt;
            if (nxt % 4 != 0 || nxt < C_IM_LO || nxt > C_IM_HI) model_err = 1'b1;
        end
        e.pc  = model_pc;
        e.err = model_err;
        exp_q.push_back(e);
    endtask

    // Asynchronous reset pulse in the low clock phase, released mid high phase
    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("reset_pc", F_PC, C_PC_RESET);
        chk("reset_err", {31'd0, F_addr_err}, 32'd0);
        chk("reset_squash", {31'd0, F_squash}, 32'd0);
        model_pc  = C_PC_RESET;
        model_err = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    // Monitor: combinational outputs just before the edge, registered after
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("squash", {31'd0, F_squash}, {31'd0, e.sq});
                chk("pc8", D_PC8, e.pc8);
                @(posedge clk);
                #1;
                chk("f_pc", F_PC, e.pc);
                chk("addr_err", {31'd0, F_addr_err}, {31'd0, e.err});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] dpc, rs;
        reset = 1'b1; stall = 1'b0; D_NPCOp = 3'd0; D_b_result = 1'b0;
        D_PC = C_IM_LO; D_imm16 = '0; D_imm26 = '0; D_rs = '0;
        model_pc = C_PC_RESET; model_err = 1'b0;
        #1;
        chk("por_pc", F_PC, C_PC_RESET);
        chk("por_squash", {31'd0, F_squash}, 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;

        // Jump to 0x3010, then reset mid-run
        drive(3'd3, 1'b0, 32'h3000, 16'h0, 26'h0, 32'h3010, 1'b0);
        drive(3'd0, 1'b0, 32'h3004, 16'h0, 26'h0, 32'h0, 1'b1);
        do_reset();

        // Taken and not-taken branches
        drive(3'd1, 1'b1, 32'h3004, 16'h0003, 26'h0, 32'h0, 1'b0);
        drive(3'd1, 1'b0, 32'h3004, 16'h0003, 26'h0, 32'h0, 1'b0);
        // Not-taken likely squashes; taken likely does not
        drive(3'd4, 1'b0, 32'h3020, 16'h0005, 26'h0, 32'h0, 1'b0);
        drive(3'd4, 1'b1, 32'h3020, 16'h0005, 26'h0, 32'h0, 1'b0);
        drive(3'd2, 1'b0, 32'h3028, 16'h0, 26'h0C10, 32'h0, 1'b0);
        // Branch held by a 3-cycle stall, then released once
        for (int i = 0; i < 3; i++)
            drive(3'd4, 1'b0, 32'h3040, 16'h0010, 26'h0, 32'h0, 1'b1);
        drive(3'd1, 1'b1, 32'h3040, 16'h0010, 26'h0, 32'h0, 1'b0);
        drive(3'd0, 1'b0, 32'h3044, 16'h0010, 26'h0, 32'h0, 1'b0);
        // Misaligned jr sets the sticky error
        drive(3'd3, 1'b0, 32'h3050, 16'h0, 26'h0, 32'h0000_3002, 1'b0);
        for (int i = 0; i < 10; i++)
            drive(3'd0, 1'b0, 32'h3100, 16'h0, 26'h0, 32'h0, i[0]);
        do_reset();
        // Backward branch below IM_BASE
        drive(3'd1, 1'b1, 32'h3000, 16'hFFFE, 26'h0, 32'h0, 1'b0);
        drive(3'd0, 1'b0, 32'h3004, 16'h0, 26'h0, 32'h0, 1'b0);
        do_reset();
        // Undefined opcode behaves as sequential
        drive(3'd7, 1'b1, 32'h3000, 16'h0040, 26'h0, 32'h5000, 1'b0);
        drive(3'd5, 1'b0, 32'h3000, 16'h0040, 26'h0, 32'h5000, 1'b0);

        // Randomized traffic with periodic resets to re-arm the error flag
        for (int n = 0; n < 400; n++) begin
            if (n % 40 == 39) do_reset();
            op  = 3'($urandom_range(0, 7));
            dpc = ($urandom_range(0, 9) != 0) ? C_IM_LO + 32'($urandom_range(0, 4095)) * 32'd4
                                              : $urandom;
            rs  = ($urandom_range(0, 6) != 0) ? C_IM_LO + 32'($urandom_range(0, 4095)) * 32'd4
                                              : $urandom;
            drive(op, 1'($urandom), dpc, 16'($urandom_range(0, 65535)),
                  26'($urandom), rs, ($urandom_range(0, 3) == 0));
        end

        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_npc_fetch_pc
`default_nettype wire
